// File: rtl/heptagon_area_if.sv
// heptagon_area_if
//   Bundle between the heptagon point sorter (master) and the area/ranking
//   stage (slave).
//   cal_on        sorter -> area  : point arrays valid and stable while high
//   x_sort/y_sort sorter -> area  : 35 sorted points, heptagon i = 7i..7i+6
//   area_on       area -> sorter  : results valid, handshake back
//   area_out      area -> sorter  : floor(|2A|/2) per heptagon
//   order         area -> sorter  : heptagon indices by ascending area
interface heptagon_area_if;
  logic        cal_on;
  logic [9:0]  x_sort   [0:34];
  logic [9:0]  y_sort   [0:34];
  logic        area_on;
  logic [19:0] area_out [0:4];
  logic [2:0]  order    [0:4];

  modport master (
    output cal_on, x_sort, y_sort,
    input  area_on, area_out, order
  );

  modport slave (
    input  cal_on, x_sort, y_sort,
    output area_on, area_out, order
  );
endinterface

// File: rtl/heptagon_area.sv
// heptagon_area
//   Computes the area of five 7-point polygons with the shoelace formula
//   (one cross term per cycle), then ranks the five areas with a fixed
//   10-cycle stable bubble sort. Latency from the cal_on sample to area_on
//   is 50 cycles.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears all state and outputs
//   bus    heptagon_area_if slave modport (cal_on, x_sort, y_sort in;
//          area_on, area_out, order out)
module heptagon_area (
  input logic             clk,
  input logic             reset,
  heptagon_area_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, MAC, STORE, SORT, DONE} state_t;

  state_t             state;
  logic [2:0]         i;      // heptagon being accumulated
  logic [2:0]         k;      // vertex within heptagon
  logic [2:0]         p;      // bubble-sort pass
  logic [2:0]         c;      // bubble-sort compare position
  logic signed [24:0] acc;

  // Cross term for the current edge (k -> k+1, wrapping 6 -> 0).
  logic [2:0]         k_next;
  logic [5:0]         base, idx_a, idx_b;
  logic [9:0]         xa, ya, xb, yb;
  logic signed [20:0] prod_ab, prod_ba;
  logic signed [24:0] term;
  logic [24:0]        abs_acc;
  logic [19:0]        area_val;

  // Bubble-sort compare of neighbours order[c], order[c+1].
  logic [2:0]         c_next;
  logic [2:0]         oa, ob;
  logic               swap;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    k_next  = (k == 3'd6) ? 3'd0 : k + 3'd1;
    base    = {3'b000, i} * 6'd7;
    idx_a   = base + {3'b000, k};
    idx_b   = base + {3'b000, k_next};
    xa      = bus.x_sort[idx_a];
    ya      = bus.y_sort[idx_a];
    xb      = bus.x_sort[idx_b];
    yb      = bus.y_sort[idx_b];
    // Unsigned coordinates are zero-extended so the signed multiply never
    // sees a negative operand; each product fits 21 signed bits.
    prod_ab = $signed({11'd0, xa}) * $signed({11'd0, yb});
    prod_ba = $signed({11'd0, xb}) * $signed({11'd0, ya});
    term    = 25'(prod_ab) - 25'(prod_ba);
    // Orientation (CW vs CCW) only flips the sign of 2A.
    abs_acc  = acc[24] ? 25'(-acc) : 25'(acc);
    area_val = 20'(abs_acc >> 1);

    c_next = c + 3'd1;
    oa     = bus.order[c];
    ob     = bus.order[c_next];
    // Strict compare keeps equal areas in index order (stable).
    swap   = bus.area_out[oa] > bus.area_out[ob];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge value of every other one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      i           <= '0;
      k           <= '0;
      p           <= '0;
      c           <= '0;
      acc         <= '0;
      bus.area_on <= 1'b0;
      // NOTE: the result arrays are small register files, not RAM, so they
      // are cleared element by element here.
      for (int n = 0; n < 5; n++) begin
        bus.area_out[n] <= '0;
        bus.order[n]    <= 3'(n);
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.cal_on) begin
            i     <= '0;
            k     <= '0;
            acc   <= '0;
            state <= MAC;
          end
        end

        MAC: begin
          acc <= acc + term;
          if (k == 3'd6) state <= STORE;
          else           k     <= k + 3'd1;
        end

        STORE: begin
          bus.area_out[i] <= area_val;
          acc             <= '0;
          k               <= '0;
          if (i == 3'd4) begin
            p     <= '0;
            c     <= '0;
            state <= SORT;
            for (int n = 0; n < 5; n++) bus.order[n] <= 3'(n);
          end else begin
            i     <= i + 3'd1;
            state <= MAC;
          end
        end

        SORT: begin
          if (swap) begin
            bus.order[c]      <= ob;
            bus.order[c_next] <= oa;
          end
          // Pass p compares positions 0..3-p: 4+3+2+1 = 10 cycles total.
          if (c == 3'd3 - p) begin
            c <= '0;
            if (p == 3'd3) begin
              bus.area_on <= 1'b1;
              state       <= DONE;
            end else begin
              p <= p + 3'd1;
            end
          end else begin
            c <= c_next;
          end
        end

        DONE: begin
          if (!bus.cal_on) begin
            bus.area_on <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heptagon_area.sv
// tb_heptagon_area
//   Directed bench for heptagon_area. A shoelace/stable-rank model computed
//   from the point tables gives the expected results; one compare process
//   checks every output whenever area_on is high, and the directed sequence
//   checks latency, handshake and reset behaviour plus literal values.
module tb_heptagon_area;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  heptagon_area_if bus ();

  heptagon_area dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int px [35];
  int py [35];
  int exp_area  [5];
  int exp_order [5];
  bit model_armed = 1'b0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // ---------------- model ----------------
  function automatic int model_area(input int h);
    longint s = 0;
    for (int k = 0; k < 7; k++) begin
      int a = 7 * h + k;
      int b = 7 * h + (k + 1) % 7;
      s += longint'(px[a]) * py[b] - longint'(px[b]) * py[a];
    end
    if (s < 0) s = -s;
    return int'(s / 2);
  endfunction

  task automatic build_model();
    bit used [5];
    for (int h = 0; h < 5; h++) begin
      exp_area[h] = model_area(h);
      used[h]     = 1'b0;
    end
    // Repeatedly take the smallest remaining area, lowest index on ties.
    for (int r = 0; r < 5; r++) begin
      int best = -1;
      for (int h = 0; h < 5; h++)
        if (!used[h] && (best < 0 || exp_area[h] < exp_area[best])) best = h;
      exp_order[r] = best;
      used[best]   = 1'b1;
    end
  endtask

  // ---------------- point tables ----------------
  task automatic clear_points();
    for (int n = 0; n < 35; n++) begin
      px[n] = 0;
      py[n] = 0;
    end
  endtask

  task automatic set_pt(input int h, input int k, input int x, input int y);
    px[7 * h + k] = x;
    py[7 * h + k] = y;
  endtask

  task automatic shape_ccw(input int h);
    set_pt(h, 0, 0, 0); set_pt(h, 1, 4, 0); set_pt(h, 2, 6, 2); set_pt(h, 3, 6, 5);
    set_pt(h, 4, 3, 7); set_pt(h, 5, 0, 5); set_pt(h, 6, 0, 2);
  endtask

  task automatic shape_cw(input int h);
    set_pt(h, 0, 0, 0); set_pt(h, 1, 0, 2); set_pt(h, 2, 0, 5); set_pt(h, 3, 3, 7);
    set_pt(h, 4, 6, 5); set_pt(h, 5, 6, 2); set_pt(h, 6, 4, 0);
  endtask

  task automatic shape_rect(input int h, input int w, input int t);
    set_pt(h, 0, 0, 0); set_pt(h, 1, w, 0); set_pt(h, 2, w, t);
    for (int k = 3; k < 7; k++) set_pt(h, k, 0, t);
  endtask

  task automatic shape_floor(input int h);
    set_pt(h, 0, 0, 0); set_pt(h, 1, 1, 0);
    for (int k = 2; k < 7; k++) set_pt(h, k, 0, 1);
  endtask

  task automatic drive_points();
    for (int n = 0; n < 35; n++) begin
      bus.x_sort[n] = 10'(px[n]);
      bus.y_sort[n] = 10'(py[n]);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (model_armed && bus.area_on === 1'b1) begin
      for (int h = 0; h < 5; h++)
        check($sformatf("area_out[%0d]", h), bus.area_out[h], exp_area[h]);
      for (int r = 0; r < 5; r++)
        check($sformatf("order[%0d]", r), bus.order[r], exp_order[r]);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, " area_on"}, bus.area_on, 0);
    for (int n = 0; n < 5; n++) begin
      check($sformatf("%s area_out[%0d]", tag, n), bus.area_out[n], 0);
      check($sformatf("%s order[%0d]", tag, n), bus.order[n], n);
    end
  endtask

  // Raise cal_on, let the DUT sample it (E0), count edges until area_on.
  task automatic start_and_wait(input string tag, input bit pulse);
    int lat;
    @(negedge clk);
    bus.cal_on = 1'b1;
    @(posedge clk);
    #1;
    if (pulse) bus.cal_on = 1'b0;
    lat = 0;
    while (bus.area_on !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, 50);
  endtask

  // Drop cal_on (if still high); area_on must fall on the next edge.
  task automatic release_and_check(input string tag);
    bus.cal_on = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " area_on falls"}, bus.area_on, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    bus.cal_on = 1'b0;
    clear_points();
    drive_points();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Heptagon 0 CCW, others zero.
    clear_points();
    shape_ccw(0);
    drive_points();
    build_model();
    check("model ccw area", exp_area[0], 34);
    model_armed = 1'b1;
    start_and_wait("ccw", 1'b0);
    check("ccw area_out[0]", bus.area_out[0], 34);
    check("ccw order[0]", bus.order[0], 1);
    check("ccw order[4]", bus.order[4], 0);
    release_and_check("ccw");

    // Same points CW in heptagon 0, floor case in heptagon 1; cal_on pulsed.
    clear_points();
    shape_cw(0);
    shape_floor(1);
    drive_points();
    build_model();
    check("model floor area", exp_area[1], 0);
    start_and_wait("cw pulse", 1'b1);
    check("cw area_out[0]", bus.area_out[0], 34);
    check("floor area_out[1]", bus.area_out[1], 0);
    release_and_check("cw pulse");

    // Maximum area in heptagon 3; cal_on held 20 cycles past area_on.
    clear_points();
    shape_rect(3, 1023, 1023);
    drive_points();
    build_model();
    check("model max area", exp_area[3], 1046529);
    start_and_wait("max", 1'b0);
    check("max area_out[3]", bus.area_out[3], 1046529);
    check("max order[4]", bus.order[4], 3);
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      check("hold area_on", bus.area_on, 1);
    end
    release_and_check("hold");

    // Ranking with a tie: areas 34, 12, 34, 0, 5.
    clear_points();
    shape_ccw(0);
    shape_rect(1, 4, 3);
    shape_cw(2);
    shape_rect(4, 5, 1);
    drive_points();
    build_model();
    check("model tie order[0]", exp_order[0], 3);
    check("model tie order[2]", exp_order[2], 1);
    check("model tie order[3]", exp_order[3], 0);
    check("model tie order[4]", exp_order[4], 2);
    start_and_wait("tie", 1'b0);
    check("tie order[0]", bus.order[0], 3);
    check("tie order[1]", bus.order[1], 4);
    check("tie order[2]", bus.order[2], 1);
    check("tie order[3]", bus.order[3], 0);
    check("tie order[4]", bus.order[4], 2);
    check("tie area_out[1]", bus.area_out[1], 12);
    check("tie area_out[4]", bus.area_out[4], 5);
    release_and_check("tie");

    // Reset sampled on edge 17 of a run.
    model_armed = 1'b0;
    @(negedge clk);
    bus.cal_on = 1'b1;
    @(posedge clk);
    repeat (16) @(posedge clk);
    #1;
    check("midrun area_out[1] after E16", bus.area_out[1], 12);
    check("midrun area_on", bus.area_on, 0);
    reset      = 1'b1;
    bus.cal_on = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrun reset");
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post-reset idle area_on", bus.area_on, 0);
    end

    // Fresh run after the abort.
    clear_points();
    shape_ccw(2);
    shape_rect(0, 5, 1);
    drive_points();
    build_model();
    model_armed = 1'b1;
    start_and_wait("after reset", 1'b0);
    check("after reset area_out[2]", bus.area_out[2], 34);
    check("after reset area_out[0]", bus.area_out[0], 5);
    check("after reset order[4]", bus.order[4], 2);
    release_and_check("after reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/heptagon_area.md
# heptagon_area

Downstream stage of the heptagon point sorter. Once the sorter raises `cal_on`, the block:
- computes the area of each of the five heptagons from the 35 angularly-ordered points, using the shoelace formula with one cross term per cycle;
- ranks the five areas in ascending order;
- raises `area_on` so the sorter can drop `cal_on`.

## Interface
Parameters: none (fixed at 5 heptagons × 7 points, 10-bit coordinates).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state and outputs
- cal_on  in  1  level from sorter: point arrays valid and held stable while high
- x_sort[0:34]  in  10 each  sorted X, unsigned; heptagon i uses entries 7i..7i+6, CCW or CW order
- y_sort[0:34]  in  10 each  sorted Y, unsigned, same indexing
- area_on  out  1  results valid; handshake back to sorter
- area_out[0:4]  out  20 each  area of heptagon n, unsigned, floor(|2A|/2)
- order[0:4]  out  3 each  heptagon indices sorted by ascending area

## Operation
States: IDLE, MAC, STORE, SORT, DONE.

- **IDLE:** waits for `cal_on`. On `cal_on`=1, clear `i`, `k` and the accumulator, then go to MAC.
- **MAC:** accumulator `acc` is 25-bit signed.
  - Each cycle adds x[7i+k]*y[7i+k'] − x[7i+k']*y[7i+k], where k' = (k+1) mod 7.
  - Operands are zero-extended to signed before multiplying; each product is 21-bit.
  - k runs 0..6. After k=6, go to STORE.
- **STORE:**
  - area_out[i] <= |acc| >> 1 (drop the LSB).
  - Clear `acc`, set k=0.
  - If i=4, go to SORT; otherwise i<=i+1 and return to MAC.
- **SORT:** bubble sort on `order`, fixed 10 compare cycles: pass p=0..3, compare c=0..3−p.
  - Swap order[c] and order[c+1] only when area_out[order[c]] > area_out[order[c+1]] (strictly greater).
  - Equal areas therefore keep the lower index first (stable sort).
  - At the start of SORT, `order` is re-initialised to {0,1,2,3,4}.
- **DONE:** `area_on`=1.
  - While `cal_on`=1, stay in DONE.
  - When `cal_on`=0 is sampled, `area_on`<=0 and go to IDLE.

Boundary behaviour:
- `cal_on` dropping during MAC/STORE/SORT is ignored; the run completes. If `cal_on` is already low on entry to DONE, `area_on` is high for exactly one cycle.
- Inputs are sampled combinationally during MAC. Changing them while busy is illegal; the result is undefined but the FSM must not hang.
- Zero-area and collinear heptagons are legal and give area 0.
- Maximum |2A| = 2·1023² = 2,093,058; the 25-bit accumulator covers the worst partial sum of ±7·1023².
- `reset` has priority over every state. It clears state to IDLE, `area_on`=0, all area_out=0, order[n]=n, acc=0, i=k=0.
- `reset` mid-run aborts immediately; no partial results are kept.

## Timing
- Edge E0: IDLE samples `cal_on`=1.
- Heptagon i: MAC on edges E(1+8i)..E(7+8i), STORE on E(8+8i). Last STORE is on E40.
- SORT occupies E41..E50. `area_on` is high after E50, giving a fixed latency of 50 cycles from E0.
- area_out[i] updates after its STORE edge. `order` is final after E50.
- Both area_out and order hold until the next start or reset.
- Back-to-back runs: after `area_on` falls, IDLE needs one cycle with `cal_on` low before a new rise is accepted. A `cal_on` that is still high is not a new run.

## Test plan
- **Heptagon 0, CCW:** (0,0),(4,0),(6,2),(6,5),(3,7),(0,5),(0,2), others all-zero. Expect area_out = {34,0,0,0,0}, order = {1,2,3,4,0}, `area_on` rises exactly 50 cycles after `cal_on` is sampled.
- **Same points in CW order:** area_out[0]=34 (signed sum −68). Floor case: (0,0),(1,0) then (0,1)×5 gives 0.
- **Maximum:** (0,0),(1023,0),(1023,1023),(0,1023)×4 in heptagon 3. Expect area_out[3]=1,046,529, no overflow, order[4]=3.
- **Ranking with tie:** areas 34, 12, 34, 0, 5 in heptagons 0..4. Expect order = {3,4,1,0,2}.
- **Handshake:**
  - `cal_on` held high 20 cycles past `area_on`: `area_on` stays high; it falls one cycle after `cal_on` falls, then IDLE.
  - `cal_on` pulsed 1 cycle: run completes and `area_on` pulses 1 cycle.
- **Reset mid-MAC (cycle 17):** all outputs are reset values next cycle and the FSM is in IDLE. A new `cal_on` then produces correct results 50 cycles later.
